ss_scan_driver: RTL and testbench

//  Time-multiplexed 4-digit common-anode 7-segment scan driver. Holds a 4-digit BCD value,

---
 rtl/ss_scan_driver.sv | 121 ++++++++++++
 tb/tb_ss_scan_driver.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_scan_driver.sv
// Four-digit common-anode 7-segment scan driver: one BCD digit per slot, blanked
// slot start for anti-ghosting, frame-aligned value commits and leading-zero blanking.
module ss_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int DIV_WIDTH    = 17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  digit_out,
  input  logic [6:0]  sseg_in,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  an
);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(REFRESH_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] CNT_ON   = DIV_WIDTH'(BLANK_CYCLES);

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [15:0]          disp_q, disp_d, shadow_q, shadow_d;
  logic [3:0]           dp_disp_q, dp_disp_d, dp_shadow_q, dp_shadow_d;
  logic                 pending_q, pending_d;
  logic                 load_ack_q, load_ack_d;
  logic                 slot_blank_q, slot_blank_d;
  logic [3:0]           digit_q, digit_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_out_q, dp_out_d;
  logic                 wrap, commit;
  logic [3:0]           lz_blank;

  assign wrap      = (cnt_q == CNT_LAST);
  assign commit    = wrap && (idx_q == 2'd3) && pending_q;
  assign disp_d    = commit ? shadow_q : disp_q;
  assign dp_disp_d = commit ? dp_shadow_q : dp_disp_q;

  // A digit is a leading zero when it and every digit above it are zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lz
      if (gi == 0) begin : g_units
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = blank_lz && (disp_d[15:4*gi] == '0);
      end
    end
  endgenerate

  always_comb begin
    cnt_d        = wrap ? '0 : cnt_q + 1'b1;
    idx_d        = wrap ? idx_q + 2'd1 : idx_q;
    state_d      = (cnt_d < CNT_ON) ? ST_BLANK : ST_ON;
    shadow_d     = load ? value_in : shadow_q;
    dp_shadow_d  = load ? dp_in : dp_shadow_q;
    pending_d    = load | (pending_q & ~commit);
    load_ack_d   = commit;
    slot_blank_d = wrap ? lz_blank[idx_d] : slot_blank_q;
    digit_d      = disp_d[4*idx_d +: 4];

    // Decoder output has settled over the blank interval; latch it on the last blank cycle.
    seg_d    = seg_q;
    dp_out_d = dp_out_q;
    if (state_q == ST_BLANK && state_d == ST_ON) begin
      seg_d    = slot_blank_q ? 7'h7F : sseg_in;
      dp_out_d = slot_blank_q | ~dp_disp_q[idx_q];
    end

    an_d = 4'hF;
    if (state_d == ST_ON && !slot_blank_d) an_d[idx_d] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      disp_q       <= 16'h0000;
      shadow_q     <= 16'h0000;
      dp_disp_q    <= 4'h0;
      dp_shadow_q  <= 4'h0;
      pending_q    <= 1'b0;
      load_ack_q   <= 1'b0;
      slot_blank_q <= 1'b0;
      digit_q      <= 4'h0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_out_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      dp_disp_q    <= dp_disp_d;
      dp_shadow_q  <= dp_shadow_d;
      pending_q    <= pending_d;
      load_ack_q   <= load_ack_d;
      slot_blank_q <= slot_blank_d;
      digit_q      <= digit_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_out_q     <= dp_out_d;
    end
  end

  assign load_ack  = load_ack_q;
  assign digit_out = digit_q;
  assign seg_out   = seg_q;
  assign dp_out    = dp_out_q;
  assign an        = an_q;

endmodule

// File: tb/tb_ss_scan_driver.sv
// Bench for ss_scan_driver: behavioural decoder in the loop and a frame/slot
// timing model derived from the cycle count since reset release.
module tb_ss_scan_driver;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] value_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic        load_ack;
  logic [3:0]  digit_out;
  logic [6:0]  sseg_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ss_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .DIV_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .load(load), .load_ack(load_ack), .digit_out(digit_out),
    .sseg_in(sseg_in), .seg_out(seg_out), .dp_out(dp_out), .an(an)
  );

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40; 4'd1: return 7'h79; 4'd2: return 7'h24; 4'd3: return 7'h30;
      4'd4: return 7'h19; 4'd5: return 7'h12; 4'd6: return 7'h02; 4'd7: return 7'h78;
      4'd8: return 7'h00; 4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  assign sseg_in = dec(digit_out);

  function automatic logic [3:0] nib(input logic [15:0] v, input int unsigned i);
    return v[4*i +: 4];
  endfunction

  function automatic int unsigned top_digit(input logic [15:0] v);
    int unsigned r = 0;
    for (int i = 0; i < 4; i++) if (nib(v, i) != 4'h0) r = i;
    return r;
  endfunction

  // Reference model: time position from cycle count, value semantics from the rules.
  int unsigned m_t, m_pos, m_slot, m_nslot;
  logic [15:0] m_disp, m_shadow, m_ndisp;
  logic [3:0]  m_dpd, m_dps, exp_an, exp_digit;
  logic        m_pend, m_ack, m_blank, m_dp, m_commit;
  logic [6:0]  m_seg;

  assign m_pos     = m_t % RD;
  assign m_slot    = (m_t / RD) % 4;
  assign m_nslot   = ((m_t + 1) / RD) % 4;
  assign m_commit  = (m_pos == RD - 1) && (m_slot == 3) && m_pend;
  assign m_ndisp   = m_commit ? m_shadow : m_disp;
  assign exp_an    = (m_pos < BC || m_blank) ? 4'hF : ~(4'b0001 << m_slot);
  assign exp_digit = nib(m_disp, m_slot);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_t <= 0; m_disp <= '0; m_shadow <= '0; m_dpd <= '0; m_dps <= '0;
      m_pend <= 1'b0; m_ack <= 1'b0; m_blank <= 1'b0; m_seg <= 7'h7F; m_dp <= 1'b1;
    end else begin
      m_t <= m_t + 1;
      m_ack <= m_commit;
      if (m_commit) begin
        m_disp <= m_shadow;
        m_dpd  <= m_dps;
      end
      if (load) begin
        m_shadow <= value_in;
        m_dps    <= dp_in;
        m_pend   <= 1'b1;
      end else if (m_commit) begin
        m_pend <= 1'b0;
      end
      if (m_pos == RD - 1) m_blank <= blank_lz && (m_nslot > top_digit(m_ndisp));
      if (m_pos == BC - 1) begin
        m_seg <= m_blank ? 7'h7F : dec(nib(m_disp, m_slot));
        m_dp  <= m_blank ? 1'b1 : ~m_dpd[m_slot];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; load = 1'b0; value_in = '0; dp_in = '0; blank_lz = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) begin
      tick();
      checks += 4;
      if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%b exp=1111", an); end
      if (seg_out !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg_out); end
      if (dp_out !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp_out); end
      if (load_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", load_ack); end
    end
    reset_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_load_1234();
    int acks = 0;
    int lows[4] = '{0, 0, 0, 0};
    logic [3:0] exp_seq[4] = '{4'd4, 4'd3, 4'd2, 4'd1};
    do_reset();
    pulse_load(16'h1234, 4'h0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      checks += 5;
      if (an !== exp_an) begin failures++; $display("FAIL basic_an t=%0d got=%b exp=%b", m_t, an, exp_an); end
      if (digit_out !== exp_digit) begin failures++; $display("FAIL basic_digit t=%0d got=%h exp=%h", m_t, digit_out, exp_digit); end
      if (seg_out !== m_seg) begin failures++; $display("FAIL basic_seg t=%0d got=%h exp=%h", m_t, seg_out, m_seg); end
      if (dp_out !== m_dp) begin failures++; $display("FAIL basic_dp t=%0d got=%b exp=%b", m_t, dp_out, m_dp); end
      if (load_ack !== m_ack) begin failures++; $display("FAIL basic_ack t=%0d got=%b exp=%b", m_t, load_ack, m_ack); end
      if (load_ack === 1'b1) acks++;
      if (m_t >= FRAME && m_t < 2 * FRAME) begin
        for (int s = 0; s < 4; s++) if (an[s] === 1'b0) lows[s]++;
        if (m_pos == 0) begin
          checks++;
          if (digit_out !== exp_seq[m_slot]) begin failures++; $display("FAIL basic_seq slot=%0d got=%h exp=%h", m_slot, digit_out, exp_seq[m_slot]); end
        end
        if (an === 4'b1110) begin
          checks++;
          if (seg_out !== 7'b001_1001) begin failures++; $display("FAIL basic_seg4 got=%b exp=0011001", seg_out); end
        end
      end
      tick();
    end
    checks += 5;
    if (acks != 1) begin failures++; $display("FAIL basic_ack_count got=%0d exp=1", acks); end
    for (int s = 0; s < 4; s++)
      if (lows[s] != RD - BC) begin failures++; $display("FAIL basic_low_cycles an%0d got=%0d exp=%0d", s, lows[s], RD - BC); end
    $display("test_load_1234 done acks=%0d", acks);
  endtask

  task automatic test_leading_zero();
    int upper_lit = 0;
    do_reset();
    blank_lz = 1'b1;
    pulse_load(16'h0007, 4'hE);
    while (m_t < 2 * FRAME + 1) begin
      checks += 2;
      if (an[3:1] !== 3'b111) begin failures++; $display("FAIL lz_an_upper t=%0d got=%b exp=111", m_t, an); end
      if (an !== exp_an) begin failures++; $display("FAIL lz_an t=%0d got=%b exp=%b", m_t, an, exp_an); end
      if (an === 4'hF && m_slot != 0 && m_pos >= BC) begin
        checks++;
        if (seg_out !== 7'h7F || dp_out !== 1'b1) begin failures++; $display("FAIL lz_blank_seg t=%0d got=%h/%b exp=7f/1", m_t, seg_out, dp_out); end
      end
      tick();
    end
    blank_lz = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (an === 4'b1101 || an === 4'b1011 || an === 4'b0111) begin
        upper_lit++;
        checks++;
        if (seg_out !== 7'b100_0000) begin failures++; $display("FAIL lz_off_seg an=%b got=%b exp=1000000", an, seg_out); end
      end
      tick();
    end
    checks++;
    if (upper_lit != 6 * (RD - BC)) begin failures++; $display("FAIL lz_off_lit got=%0d exp=%0d", upper_lit, 6 * (RD - BC)); end
    $display("test_leading_zero done upper_lit=%0d", upper_lit);
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    do_reset();
    pulse_load(16'h5678, 4'h0);
    while (m_t < 3 * FRAME) begin
      if (m_t == FRAME + 2 * RD + 3) pulse_load(16'h1111, 4'h0);
      else if (m_t == FRAME + 3 * RD + 3) pulse_load(16'h2222, 4'h0);
      else tick();
      if (m_t > FRAME && load_ack === 1'b1) acks++;
      checks++;
      if (m_t > FRAME && m_t < 2 * FRAME) begin
        if (digit_out !== nib(16'h5678, m_slot)) begin failures++; $display("FAIL b2b_old t=%0d got=%h exp=%h", m_t, digit_out, nib(16'h5678, m_slot)); end
      end else if (m_t >= 2 * FRAME) begin
        if (digit_out !== nib(16'h2222, m_slot)) begin failures++; $display("FAIL b2b_new t=%0d got=%h exp=%h", m_t, digit_out, nib(16'h2222, m_slot)); end
      end else begin
        if (digit_out !== exp_digit) begin failures++; $display("FAIL b2b_first t=%0d got=%h exp=%h", m_t, digit_out, exp_digit); end
      end
    end
    checks++;
    if (acks != 1) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=1", acks); end
    $display("test_back_to_back done acks=%0d", acks);
  endtask

  task automatic test_commit_collision();
    int acks = 0;
    do_reset();
    pulse_load(16'h9A0B, 4'h0);
    while (m_t < FRAME - 1) tick();
    pulse_load(16'h0042, 4'h0);
    while (m_t < 3 * FRAME) begin
      if (load_ack === 1'b1) acks++;
      checks += 2;
      if (m_t < 2 * FRAME) begin
        if (digit_out !== nib(16'h9A0B, m_slot)) begin failures++; $display("FAIL coll_first t=%0d got=%h exp=%h", m_t, digit_out, nib(16'h9A0B, m_slot)); end
      end else begin
        if (digit_out !== nib(16'h0042, m_slot)) begin failures++; $display("FAIL coll_second t=%0d got=%h exp=%h", m_t, digit_out, nib(16'h0042, m_slot)); end
      end
      if (seg_out !== m_seg) begin failures++; $display("FAIL coll_seg t=%0d got=%h exp=%h", m_t, seg_out, m_seg); end
      tick();
    end
    checks++;
    if (acks != 2) begin failures++; $display("FAIL coll_ack_count got=%0d exp=2", acks); end
    $display("test_commit_collision done acks=%0d", acks);
  endtask

  task automatic test_dp();
    int dp_low = 0;
    do_reset();
    pulse_load(16'h1234, 4'b0100);
    while (m_t < 3 * FRAME) begin
      if (m_t >= FRAME && an !== 4'hF) begin
        checks++;
        if (dp_out !== (an === 4'b1011 ? 1'b0 : 1'b1)) begin failures++; $display("FAIL dp_lit an=%b got=%b", an, dp_out); end
        if (dp_out === 1'b0) dp_low++;
      end
      tick();
    end
    checks++;
    if (dp_low != 2 * (RD - BC)) begin failures++; $display("FAIL dp_low_count got=%0d exp=%0d", dp_low, 2 * (RD - BC)); end
    $display("test_dp done dp_low=%0d", dp_low);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      checks += 5;
      if (an !== exp_an) begin failures++; $display("FAIL rand_an t=%0d got=%b exp=%b", m_t, an, exp_an); end
      if (digit_out !== exp_digit) begin failures++; $display("FAIL rand_digit t=%0d got=%h exp=%h", m_t, digit_out, exp_digit); end
      if (seg_out !== m_seg) begin failures++; $display("FAIL rand_seg t=%0d got=%h exp=%h", m_t, seg_out, m_seg); end
      if (dp_out !== m_dp) begin failures++; $display("FAIL rand_dp t=%0d got=%b exp=%b", m_t, dp_out, m_dp); end
      if (load_ack !== m_ack) begin failures++; $display("FAIL rand_ack t=%0d got=%b exp=%b", m_t, load_ack, m_ack); end
      load = ($urandom_range(0, 9) == 0);
      value_in = 16'($urandom) >> (4 * $urandom_range(0, 3));
      dp_in = 4'($urandom);
      if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
      tick();
    end
    load = 1'b0;
    $display("test_random done t=%0d", m_t);
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    do_reset();
    pulse_load(16'h1234, 4'h0);
    while (an !== 4'b1101 && guard < 200) begin tick(); guard++; end
    checks++;
    if (an !== 4'b1101) begin failures++; $display("FAIL rstmid_wait got=%b exp=1101", an); end
    #2 reset_n = 1'b0;
    #1;
    checks += 4;
    if (an !== 4'hF) begin failures++; $display("FAIL rstmid_an got=%b exp=1111", an); end
    if (seg_out !== 7'h7F) begin failures++; $display("FAIL rstmid_seg got=%h exp=7f", seg_out); end
    if (digit_out !== 4'h0) begin failures++; $display("FAIL rstmid_digit got=%h exp=0", digit_out); end
    if (dp_out !== 1'b1) begin failures++; $display("FAIL rstmid_dp got=%b exp=1", dp_out); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (an !== 4'hF) begin failures++; $display("FAIL rstmid_blank got=%b exp=1111", an); end
    tick();
    checks += 2;
    if (an !== 4'b1110) begin failures++; $display("FAIL rstmid_slot0 got=%b exp=1110", an); end
    if (seg_out !== 7'h40) begin failures++; $display("FAIL rstmid_zero got=%h exp=40", seg_out); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_leading_zero();
    test_back_to_back();
    test_commit_collision();
    test_dp();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
